// File: rtl/givens_row_sequencer_pkg.sv
// Shared types and default constants for the Givens-rotation row sequencer.
// The defaults mirror the CORDIC array that sits directly downstream.
package givens_pkg;

   localparam int DEF_N       = 31;  // MSB index of data words
   localparam int DEF_K       = 4;   // columns per row
   localparam int DEF_LAT     = 14;  // 13 CORDIC iterations plus its output register
   localparam int DEF_LAT_BYP = 1;   // CORDIC path taken when a==0 or b==0

   // Column index width carried by a token; sized for the default row length.
   localparam int COL_W = $clog2(DEF_K);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_ISSUE,
      ST_DRAIN
   } state_t;

   // Tag that travels beside a column while the CORDIC works on it.
   typedef struct packed {
      logic [COL_W-1:0] col;
      logic             last;
   } token_t;

   localparam int TOK_W = $bits(token_t);

endpackage

// File: rtl/givens_row_sequencer_delay.sv
// Valid-tagged shift line that shadows the CORDIC pipeline. Two taps are
// provided: the full-depth tap for the rotate path and a short tap for the
// CORDIC bypass path.
module valid_delay_line #(
   parameter int DEPTH   = 14,
   parameter int BYP_TAP = 1,
   parameter int W       = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_vld,
   input  logic [W-1:0] i_tok,
   input  logic         i_sel_byp,
   output logic         o_vld,
   output logic [W-1:0] o_tok
);

   // r_vld[m] / r_tok[m] hold the token m+1 cycles after it entered.
   logic [DEPTH-1:0] r_vld;
   logic [W-1:0]     r_tok [DEPTH];

   // Valid bits: cleared on reset, and flushed between rows so tokens left
   // behind the short tap cannot reappear at the long tap later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else if (i_flush) begin
         r_vld <= '0;
      end else begin
         r_vld <= {r_vld[DEPTH-2:0], i_vld};
      end
   end

   // Token payload shifts unconditionally; it is only meaningful beside r_vld.
   always_ff @(posedge clk) begin
      r_tok[0] <= i_tok;
      for (int m = 1; m < DEPTH; m++) begin
         r_tok[m] <= r_tok[m-1];
      end
   end

   assign o_vld = i_sel_byp ? r_vld[BYP_TAP-1] : r_vld[DEPTH-1];
   assign o_tok = i_sel_byp ? r_tok[BYP_TAP-1] : r_tok[DEPTH-1];

endmodule

// File: rtl/givens_row_sequencer.sv
// Row sequencer for Givens QR: buffers one X/Y row pair, streams the pivot and
// each column into the CORDIC array, and re-times the CORDIC results into a
// valid-tagged column stream.
module givens_row_sequencer
   import givens_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int K       = DEF_K,
   parameter int LAT     = DEF_LAT,
   parameter int LAT_BYP = DEF_LAT_BYP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [N:0]    in_x,
   input  logic signed [N:0]    in_y,
   output logic signed [N:0]    cor_a,
   output logic signed [N:0]    cor_b,
   output logic signed [N:0]    cor_p,
   output logic signed [N:0]    cor_q,
   input  logic signed [N:0]    cor_pf,
   input  logic signed [N:0]    cor_qf,
   input  logic [15:0]          cor_angle,
   output logic                 out_valid,
   output logic [$clog2(K)-1:0] out_col,
   output logic signed [N:0]    out_p,
   output logic signed [N:0]    out_q,
   output logic [15:0]          out_angle,
   output logic                 out_last,
   output logic                 busy
);

   localparam int            CW       = $clog2(K);
   localparam logic [CW-1:0] LAST_COL = CW'(K - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_load_done;
   logic                  w_issue;
   logic                  w_drain_done;

   logic [CW-1:0]         r_ld_cnt;
   logic [CW-1:0]         r_iss_cnt;
   logic                  r_in_ready;
   logic                  r_byp;

   logic signed [N:0]     r_buf_x [K];
   logic signed [N:0]     r_buf_y [K];
   logic signed [N:0]     w_x0;
   logic signed [N:0]     w_y0;

   logic signed [N:0]     r_cor_a;
   logic signed [N:0]     r_cor_b;
   logic signed [N:0]     r_cor_p;
   logic signed [N:0]     r_cor_q;
   logic                  r_iss_vld;
   token_t                r_iss_tok;

   logic                  w_tap_vld;
   token_t                w_tap_tok;

   logic                  r_out_valid;
   logic [CW-1:0]         r_out_col;
   logic signed [N:0]     r_out_p;
   logic signed [N:0]     r_out_q;
   logic [15:0]           r_out_angle;
   logic                  r_out_last;

   // When the final beat lands in slot 0 the pivot is still on the input bus.
   assign w_x0 = (r_ld_cnt == '0) ? in_x : r_buf_x[0];
   assign w_y0 = (r_ld_cnt == '0) ? in_y : r_buf_y[0];

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_LOAD;
      else      r_state <= w_state_nxt;
   end

   // Next-state and per-state strobes.
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_load_done  = 1'b0;
      w_issue      = 1'b0;
      w_drain_done = 1'b0;
      unique case (r_state)
         ST_LOAD: begin
            w_accept    = in_valid & r_in_ready;
            w_load_done = w_accept & (r_ld_cnt == LAST_COL);
            if (w_load_done) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_issue = 1'b1;
            if (r_iss_cnt == LAST_COL) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // One row at a time in the CORDIC: leave only once the last column is out.
            w_drain_done = r_out_valid & r_out_last;
            if (w_drain_done) w_state_nxt = ST_LOAD;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Load/issue counters and the registered ready (low throughout reset).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ld_cnt   <= '0;
         r_iss_cnt  <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_in_ready <= (w_state_nxt == ST_LOAD);
         if (w_accept) r_ld_cnt <= (r_ld_cnt == LAST_COL) ? '0 : r_ld_cnt + 1'b1;
         if (w_issue)  r_iss_cnt <= (r_iss_cnt == LAST_COL) ? '0 : r_iss_cnt + 1'b1;
      end
   end

   // Row buffer; the contents survive stalls in the input stream.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf_x[r_ld_cnt] <= in_x;
         r_buf_y[r_ld_cnt] <= in_y;
      end
   end

   // Pivot and bypass flag are captured once per row and held through DRAIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cor_a <= '0;
         r_cor_b <= '0;
         r_byp   <= 1'b0;
      end else if (w_load_done) begin
         r_cor_a <= w_x0;
         r_cor_b <= w_y0;
         r_byp   <= (w_x0 == '0) || (w_y0 == '0);
      end
   end

   // Issue stage: column operands and their token leave on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cor_p   <= '0;
         r_cor_q   <= '0;
         r_iss_vld <= 1'b0;
         r_iss_tok <= '0;
      end else begin
         r_iss_vld <= w_issue;
         if (w_issue) begin
            r_cor_p        <= r_buf_x[r_iss_cnt];
            r_cor_q        <= r_buf_y[r_iss_cnt];
            r_iss_tok.col  <= COL_W'(r_iss_cnt);
            r_iss_tok.last <= (r_iss_cnt == LAST_COL);
         end
      end
   end

   valid_delay_line #(
      .DEPTH   (LAT),
      .BYP_TAP (LAT_BYP),
      .W       (TOK_W)
   ) u_dly (
      .clk       (clk),
      .rst_n     (rst),
      .i_flush   (w_drain_done),
      .i_vld     (r_iss_vld),
      .i_tok     (r_iss_tok),
      .i_sel_byp (r_byp),
      .o_vld     (w_tap_vld),
      .o_tok     (w_tap_tok)
   );

   // Result stage: capture the CORDIC outputs in the cycle the token reaches its tap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_col   <= '0;
         r_out_p     <= '0;
         r_out_q     <= '0;
         r_out_angle <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_out_valid <= w_tap_vld;
         r_out_last  <= w_tap_vld & w_tap_tok.last;
         if (w_tap_vld) begin
            r_out_col   <= CW'(w_tap_tok.col);
            r_out_p     <= cor_pf;
            r_out_q     <= cor_qf;
            r_out_angle <= r_byp ? 16'h0000 : cor_angle;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign cor_a     = r_cor_a;
   assign cor_b     = r_cor_b;
   assign cor_p     = r_cor_p;
   assign cor_q     = r_cor_q;
   assign out_valid = r_out_valid;
   assign out_col   = r_out_col;
   assign out_p     = r_out_p;
   assign out_q     = r_out_q;
   assign out_angle = r_out_angle;
   assign out_last  = r_out_last;
   assign busy      = (r_state != ST_LOAD);

endmodule

// File: tb/tb_givens_row_sequencer.sv
// Directed bench for givens_row_sequencer. A stand-in CORDIC applies easily
// recognisable transforms (p+1000, q-1000, angle = {a[7:0],b[7:0]}) on the
// rotate path and passes p/q through with a junk angle on the bypass path,
// so column identity, alignment and angle gating are all visible.
module tb_givens_row_sequencer;

   localparam int N       = 31;
   localparam int K       = 4;
   localparam int LAT     = 14;
   localparam int LAT_BYP = 1;

   typedef logic signed [N:0] row_t [K];

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic signed [N:0]     in_x = '0;
   logic signed [N:0]     in_y = '0;
   logic signed [N:0]     cor_a, cor_b, cor_p, cor_q;
   logic signed [N:0]     cor_pf, cor_qf;
   logic [15:0]           cor_angle;
   logic                  out_valid;
   logic [$clog2(K)-1:0]  out_col;
   logic signed [N:0]     out_p, out_q;
   logic [15:0]           out_angle;
   logic                  out_last;
   logic                  busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   givens_row_sequencer #(
      .N       (N),
      .K       (K),
      .LAT     (LAT),
      .LAT_BYP (LAT_BYP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .cor_a     (cor_a),
      .cor_b     (cor_b),
      .cor_p     (cor_p),
      .cor_q     (cor_q),
      .cor_pf    (cor_pf),
      .cor_qf    (cor_qf),
      .cor_angle (cor_angle),
      .out_valid (out_valid),
      .out_col   (out_col),
      .out_p     (out_p),
      .out_q     (out_q),
      .out_angle (out_angle),
      .out_last  (out_last),
      .busy      (busy)
   );

   // Stand-in CORDIC: LAT-deep rotate path, single-register bypass path.
   logic signed [N:0] m_rot_p [LAT];
   logic signed [N:0] m_rot_q [LAT];
   logic [15:0]       m_rot_a [LAT];
   logic signed [N:0] m_byp_p, m_byp_q;
   logic              m_byp;

   always @(posedge clk) begin
      m_rot_p[0] <= cor_p + 32'sd1000;
      m_rot_q[0] <= cor_q - 32'sd1000;
      m_rot_a[0] <= {cor_a[7:0], cor_b[7:0]};
      for (int i = 1; i < LAT; i++) begin
         m_rot_p[i] <= m_rot_p[i-1];
         m_rot_q[i] <= m_rot_q[i-1];
         m_rot_a[i] <= m_rot_a[i-1];
      end
      m_byp_p <= cor_p;
      m_byp_q <= cor_q;
   end

   assign m_byp     = (cor_a == '0) || (cor_b == '0);
   assign cor_pf    = m_byp ? m_byp_p : m_rot_p[LAT-1];
   assign cor_qf    = m_byp ? m_byp_q : m_rot_q[LAT-1];
   assign cor_angle = m_byp ? 16'hBEEF : m_rot_a[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer the row beat by beat; with toggle set, in_valid alternates 1,0,1,0.
   // Returns just after the edge that accepts the K-th beat.
   task automatic load_row(input row_t xs, input row_t ys, input bit toggle);
      int  idx = 0;
      int  cyc = 0;
      bit  offer;
      bit  acc;
      while (idx < K && cyc < 60) begin
         offer    = toggle ? (cyc % 2 == 0) : 1'b1;
         in_valid = offer;
         in_x     = offer ? xs[idx] : 32'sh0BAD0BAD;
         in_y     = offer ? ys[idx] : 32'sh0BAD0BAD;
         acc      = offer && in_ready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      chk("load_beats", idx, K);
   endtask

   // Watch the result stream for one row; n counts edges since the K-th accept.
   task automatic collect(input row_t xs, input row_t ys, input int exp_first, input bit byp);
      int          beats = 0;
      int          n = 0;
      logic [15:0] ang;
      logic signed [N:0] ep, eq;
      ang = byp ? 16'h0000 : {xs[0][7:0], ys[0][7:0]};
      while (beats < K && n < 80) begin
         tick();
         n++;
         if (out_valid) begin
            ep = byp ? xs[beats] : xs[beats] + 32'sd1000;
            eq = byp ? ys[beats] : ys[beats] - 32'sd1000;
            chk("beat_time", n, exp_first + beats);
            chk("out_col", out_col, beats);
            chk("out_p", out_p, ep);
            chk("out_q", out_q, eq);
            chk("out_angle", out_angle, ang);
            chk("out_last", out_last, (beats == K - 1));
            if (beats == K - 1) chk("ready_low_at_last", in_ready, 0);
            beats++;
         end
      end
      chk("row_beats", beats, K);
      tick();
      chk("ready_after_drain", in_ready, 1);
      chk("busy_after_drain", busy, 0);
   endtask

   initial begin
      row_t xa, ya, xb, yb, xc, yc, xd, yd;
      bit   seen;
      xa = '{32'sd3, 32'sd1, 32'sd0, 32'sd5};
      ya = '{32'sd4, 32'sd2, 32'sd7, 32'sd0};
      xb = '{32'sd0, 32'sd1, 32'sd2, 32'sd3};
      yb = '{32'sd9, 32'sd4, 32'sd5, 32'sd6};
      xc = '{32'sd10, 32'sd20, 32'sd30, 32'sd40};
      yc = '{-32'sd1, -32'sd2, -32'sd3, -32'sd4};
      xd = '{-32'sd7, 32'sd100, -32'sd200, 32'sd300};
      yd = '{32'sd2, -32'sd50, 32'sd60, -32'sd70};

      // Reset state
      rst = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cor_a", cor_a, 0);
      chk("rst_cor_p", cor_p, 0);
      chk("rst_out_p", out_p, 0);
      rst = 1'b1;
      chk("ready_before_edge", in_ready, 0);
      tick();
      chk("ready_after_release", in_ready, 1);

      // Rotate row
      load_row(xa, ya, 1'b0);
      in_valid = 1'b0;
      chk("rot_ready_low", in_ready, 0);
      chk("rot_busy", busy, 1);
      chk("rot_cor_a", cor_a, 3);
      chk("rot_cor_b", cor_b, 4);
      collect(xa, ya, 16, 1'b0);

      // Bypass row (x0 == 0)
      load_row(xb, yb, 1'b0);
      in_valid = 1'b0;
      chk("byp_cor_b", cor_b, 9);
      collect(xb, yb, 3, 1'b1);

      // Back-pressure: alternating valid, then junk offered while busy
      load_row(xc, yc, 1'b1);
      chk("bp_ready_low", in_ready, 0);
      in_valid = 1'b1;
      in_x     = 32'sh0BAD0BAD;
      in_y     = 32'sh0BAD0BAD;
      collect(xc, yc, 16, 1'b0);
      in_valid = 1'b0;

      // Reset five cycles into DRAIN
      load_row(xd, yd, 1'b0);
      in_valid = 1'b0;
      repeat (9) tick();
      chk("pre_rst_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cor_p", cor_p, 0);
      tick();
      tick();
      rst = 1'b1;
      chk("rel_ready_before_edge", in_ready, 0);
      tick();
      chk("rel_ready_after_edge", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      chk("no_valid_after_reset", seen, 0);
      load_row(xd, yd, 1'b0);
      in_valid = 1'b0;
      collect(xd, yd, 16, 1'b0);

      // Back-to-back rows with in_valid held high
      load_row(xa, ya, 1'b0);
      in_valid = 1'b1;
      in_x     = xc[0];
      in_y     = yc[0];
      collect(xa, ya, 16, 1'b0);
      load_row(xc, yc, 1'b0);
      in_valid = 1'b0;
      collect(xc, yc, 16, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
